// File: rtl/mmc1_serial_writer.sv
// mmc1_serial_writer: turns one parallel MMC1 register write (or a shift-register
// reset) into the serial CPU-bus write sequence the MMC1 load port expects.
// A register write is five one-bit writes on D0, LSB first; a reset is one write with D7=1.
// Optional build macro MMC1_GAP_CYCLE_EN: inserts one idle CPU cycle between the
// writes of a register sequence (9 CPU cycles per register write instead of 5).
module mmc1_serial_writer #(
   parameter int M2_LOW_CLKS  = 3,
   parameter int M2_HIGH_CLKS = 3,
   parameter int ROMSEL_DLY   = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_reset,
   input  logic [1:0] req_reg,
   input  logic [4:0] req_data,
   output logic       busy,
   output logic       done,
   output logic       CPU_M2,
   output logic       nCPU_ROMSEL,
   output logic       nCPU_RW,
   output logic       CPU_A14,
   output logic       CPU_A13,
   output logic       CPU_D0,
   output logic       CPU_D7
);

   localparam int PER = M2_LOW_CLKS + M2_HIGH_CLKS;
   localparam int PW  = $clog2(PER);
   localparam logic [PW-1:0] PH_LAST   = PW'(PER - 1);
   localparam logic [PW-1:0] PH_HIGH   = PW'(M2_LOW_CLKS);
   localparam logic [PW-1:0] PH_ROMSEL = PW'(M2_LOW_CLKS + ROMSEL_DLY);

`ifdef MMC1_GAP_CYCLE_EN
   typedef enum logic [1:0] {IDLE, ARMED, WRITE, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, ARMED, WRITE} state_t;
`endif

   state_t          state, state_n;
   logic [PW-1:0]   phase;
   logic            alive;      // low for the first CLK after reset so req_ready stays 0
   logic            rst_cmd;    // latched req_reset
   logic [1:0]      reg_q;
   logic [4:0]      data_q;
   logic [2:0]      bit_q, bit_n;
   logic [1:0]      addr_q;
   logic            done_q, done_n;
   logic            load, start;
   logic            boundary, last;
   logic            in_wr;

   // next CLK edge moves the phase counter back to 0: the CPU cycle boundary
   assign boundary = (phase == PH_LAST);
   // the write in progress is the final one of its request
   assign last     = rst_cmd || (bit_q == 3'd4);

   // next-state, bit counter and completion decode
   always_comb begin
      state_n = state;
      bit_n   = bit_q;
      done_n  = 1'b0;
      load    = 1'b0;
      start   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_n = ARMED;
               load    = 1'b1;
            end
         end
         ARMED: begin
            if (boundary) begin
               state_n = WRITE;
               bit_n   = 3'd0;
               start   = 1'b1;
            end
         end
         WRITE: begin
            if (boundary) begin
               if (last) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
`ifdef MMC1_GAP_CYCLE_EN
                  state_n = GAP;
`else
                  bit_n   = (bit_q < 3'd4) ? bit_q + 3'd1 : bit_q;
`endif
               end
            end
         end
`ifdef MMC1_GAP_CYCLE_EN
         GAP: begin
            if (boundary) begin
               state_n = WRITE;
               bit_n   = (bit_q < 3'd4) ? bit_q + 3'd1 : bit_q;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_n;
   end

   // free-running phase counter, request latch, bit counter, address and done pulse
   always_ff @(posedge CLK) begin
      if (RST) begin
         phase   <= '0;
         alive   <= 1'b0;
         rst_cmd <= 1'b0;
         reg_q   <= 2'b00;
         data_q  <= 5'd0;
         bit_q   <= 3'd0;
         addr_q  <= 2'b00;
         done_q  <= 1'b0;
      end else begin
         phase  <= boundary ? '0 : phase + PW'(1);
         alive  <= 1'b1;
         done_q <= done_n;
         bit_q  <= bit_n;
         if (load) begin
            rst_cmd <= req_reset;
            reg_q   <= req_reg;
            data_q  <= req_data;
         end
         // address is set at the start of a sequence and then held, also across idle time
         if (start) addr_q <= rst_cmd ? 2'b00 : reg_q;
      end
   end

   assign in_wr       = (state == WRITE);
   assign req_ready   = alive && (state == IDLE);
   assign busy        = (state != IDLE);
   assign done        = done_q;
   assign CPU_M2      = (phase >= PH_HIGH);
   assign nCPU_RW     = !in_wr;
   assign nCPU_ROMSEL = !(in_wr && (phase >= PH_ROMSEL));
   assign CPU_A14     = addr_q[1];
   assign CPU_A13     = addr_q[0];
   assign CPU_D0      = in_wr && !rst_cmd && data_q[bit_q];
   assign CPU_D7      = in_wr && rst_cmd;

endmodule

// File: doc/mmc1_serial_writer.md
Name: mmc1_serial_writer

Overview:
- Bus-side master for the MMC1 serial load port. It turns one parallel register-write request into the MMC1 CPU-bus write sequence.
- A register write becomes five single-bit writes, D0 carrying data LSB first; a shift-register reset becomes a single write with D7=1.
- Drives CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14/A13, CPU_D0, CPU_D7 toward the mapper.
- Used by the cartridge test harness and the flash/programmer front end.

Parameters:
- M2_LOW_CLKS, 3, CLK cycles per M2-low phase (>=1).
- M2_HIGH_CLKS, 3, CLK cycles per M2-high phase (>=2).
- ROMSEL_DLY, 1, CLK cycles after M2 rise before nCPU_ROMSEL falls (0..M2_HIGH_CLKS-1).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready at CLK edge
- req_reset  in  1  1 = shift-register reset command (req_reg and req_data ignored)
- req_reg  in  2  target register, drives {CPU_A14,CPU_A13}: 00 control, 01 CHR0, 10 CHR1, 11 PRG
- req_data  in  5  register value
- busy  out  1  sequence in progress
- done  out  1  one-CLK pulse at end of last write cycle
- CPU_M2  out  1  free-running M2
- nCPU_ROMSEL  out  1  low only during M2-high part of write cycles
- nCPU_RW  out  1  0 for a whole write cycle
- CPU_A14, CPU_A13  out  1 each  register select
- CPU_D0, CPU_D7  out  1 each  serial data and reset bit

Behaviour:
- Phase counter 0..L+H-1, where L=M2_LOW_CLKS and H=M2_HIGH_CLKS, wraps continuously. CPU_M2=0 for counts 0..L-1 and 1 for counts L..L+H-1. A count of 0 is the cycle boundary.
- States: IDLE, ARMED, WRITE, GAP (GAP exists only with the optional feature).
- Accept: req_ready=1 only in IDLE. The request is latched on the accepting edge; state goes to ARMED and busy=1 on the next CLK.
- ARMED to WRITE at the next cycle boundary. Start latency is 1..L+H CLKs.
- WRITE cycle:
  - At the boundary: drive address, data and nCPU_RW=0.
  - At count L+ROMSEL_DLY: nCPU_ROMSEL=0.
  - At the boundary that ends the cycle: nCPU_ROMSEL=1 and nCPU_RW=1.
  - Address and data stay stable for the whole cycle.
- Register request: 5 write cycles with bit counter i=0..4. CPU_D0=req_data[i], CPU_D7=0.
- Reset request: 1 write cycle with CPU_D7=1, CPU_D0=0, A14/A13=00.
- Completion: done=1 on the CLK after the final cycle ends. State returns to IDLE, busy=0 and req_ready=1 on that same CLK.
- Back-to-back requests: each new request still waits for the next boundary after acceptance. Writes from separate requests are therefore never in adjacent CPU cycles.
- Idle cycles: M2 keeps toggling; nCPU_ROMSEL=1, nCPU_RW=1, D0=D7=0, address holds its last value.
- Reset values (RST high, and the CLK after it): phase=0, CPU_M2=0, nCPU_ROMSEL=1, nCPU_RW=1, A14=A13=0, D0=D7=0, busy=0, done=0, req_ready=0. req_ready=1 from the first CLK after RST is released.
- RST mid-sequence aborts immediately with no further bus activity. The mapper may be left partially shifted; the caller must issue a req_reset before the next register write.
- Request inputs are sampled only at acceptance; later changes are ignored.
- Width rules: the bit counter is 3 bits and saturates at 4. The phase counter is $clog2(L+H) bits.

Optional Feature:
- MMC1_GAP_CYCLE_EN
- Defined: between consecutive writes of a register sequence, insert one full idle CPU cycle (GAP state: nCPU_ROMSEL=1, nCPU_RW=1, D0/D7=0). A register write takes 9 CPU cycles. This is safe with mappers that ignore writes on consecutive cycles.
- Undefined: the 5 writes occupy 5 consecutive CPU cycles and the GAP state is absent. Reset requests are unaffected either way.

Test Plan:
- After RST, idle for 4 cycles → M2 period 6 CLK (3 low/3 high); nCPU_ROMSEL constant 1; req_ready=1.
- Register write, req_reg=11, req_data=5'b10110 → 5 writes, A14/A13=11, D0 sequence 0,1,1,0,1, each nCPU_ROMSEL low 2 CLK starting 1 CLK after M2 rise; done pulses once; a behavioural mapper model holds PRG=10110.
- Reset request → exactly one write with D7=1, D0=0, A14/A13=00; busy high for wait time plus 6 CLK; model load register=10000 and control |= 01100.
- Back-to-back requests, req_valid held with CHR0=01010 then CHR1=00111 → second accepted in the cycle after done; at least one idle CPU cycle between the sequences; model holds both values.
- RST asserted during the third write → nCPU_ROMSEL=1 and nCPU_RW=1 on the next CLK; no done pulse; then reset request followed by control=01111 → model control=01111.
- With MMC1_GAP_CYCLE_EN, control=00011 → writes land on CPU cycles 0,2,4,6,8; no ROMSEL activity on odd cycles; total 54 CLK from first boundary to done.
